// File: rtl/int_real_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : int_real_sequencer
// Brief    : Computes xout[3..0] from (a, b) as a six-step program issued one
//            operation at a time to a shared external real ALU (req/ack).
// Revision : 1.0 - initial release
// ============================================================================
module int_real_sequencer #(
  parameter real MUL_K   = 17.0,
  parameter real SUB_C   = 3.14,
  parameter real DIV_K   = 21.0,
  parameter real ADD_E   = 2.718281828459045,
  parameter int  TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] a,
  input  real                b,
  output logic               alu_req,
  output logic [1:0]         alu_op,
  output real                alu_x,
  output real                alu_y,
  input  logic               alu_ack,
  input  real                alu_z,
  output real                xout [4],
  output logic               done,
  output logic               err
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_commit = 2'd2;

  localparam logic [1:0] c_op_add = 2'd0;
  localparam logic [1:0] c_op_sub = 2'd1;
  localparam logic [1:0] c_op_mul = 2'd2;
  localparam logic [1:0] c_op_div = 2'd3;

  localparam logic [2:0] c_last_op = 3'd5;

  localparam int                  c_wait_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [2:0]          r_op;
  logic [c_wait_w-1:0] r_wait;
  logic                r_err;
  real                 r_s0;
  real                 r_b;
  real                 r_s;
  real                 r_t;
  real                 r_x0;
  real                 r_x2;
  real                 r_x3;
  real                 r_xout [4];

  logic w_accept;
  logic w_fire;
  logic w_timeout;

  assign w_accept  = in_valid & (r_state == c_st_idle);
  assign w_fire    = (r_state == c_st_run) & alu_ack;
  assign w_timeout = (r_state == c_st_run) & ~alu_ack & (r_wait == c_wait_max);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_run: begin
        if (w_fire && (r_op == c_last_op)) begin
          w_state_nxt = c_st_commit;
        end else if (w_timeout) begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_commit: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Operands are decoded from the op index and registers that only change on
  // an accepted result, so they stay stable for as long as req waits for ack.
  always_comb begin
    in_ready = (r_state == c_st_idle);
    alu_req  = (r_state == c_st_run);
    done     = (r_state == c_st_commit);
    alu_op   = c_op_add;
    alu_x    = 0.0;
    alu_y    = 0.0;
    if (r_state == c_st_run) begin
      case (r_op)
        3'd0: begin
          alu_op = c_op_add;
          alu_x  = r_s0;
          alu_y  = r_b;
        end
        3'd1: begin
          alu_op = c_op_mul;
          alu_x  = r_s;
          alu_y  = MUL_K;
        end
        3'd2: begin
          alu_op = c_op_sub;
          alu_x  = r_t;
          alu_y  = SUB_C;
        end
        3'd3: begin
          alu_op = c_op_div;
          alu_x  = r_s;
          alu_y  = DIV_K;
        end
        3'd4: begin
          alu_op = c_op_add;
          alu_x  = r_t;
          alu_y  = ADD_E;
        end
        default: begin
          alu_op = c_op_add;
          alu_x  = r_s;
          alu_y  = 1.0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_wait <= '0;
      r_err  <= 1'b0;
      r_s0   <= 0.0;
      r_b    <= 0.0;
      r_s    <= 0.0;
      r_t    <= 0.0;
      r_x0   <= 0.0;
      r_x2   <= 0.0;
      r_x3   <= 0.0;
      for (int i = 0; i < 4; i++) begin
        r_xout[i] <= 0.0;
      end
    end else begin
      if (w_accept) begin
        r_s0   <= $itor(a);
        r_b    <= b;
        r_op   <= '0;
        r_wait <= '0;
        r_err  <= 1'b0;
      end else if (w_fire) begin
        r_op   <= r_op + 3'd1;
        r_wait <= '0;
        case (r_op)
          3'd0: begin
            r_s  <= alu_z;
            r_x0 <= alu_z;
          end
          3'd1, 3'd3: r_t  <= alu_z;
          3'd2:       r_x3 <= alu_z;
          3'd4:       r_x2 <= alu_z;
          3'd5: begin
            // Final result goes straight into the committed set so all four
            // values appear together in the done cycle.
            r_xout[0] <= r_x0;
            r_xout[1] <= alu_z;
            r_xout[2] <= r_x2;
            r_xout[3] <= r_x3;
          end
          default: begin
          end
        endcase
      end else if (w_timeout) begin
        r_err  <= 1'b1;
        r_wait <= '0;
      end else if (r_state == c_st_run) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xout[i] = r_xout[i];
    end
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_int_real_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_real_sequencer
// Brief    : Self-checking bench: cycle-level reference timeline driven from
//            the arithmetic program, compared against the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_real_sequencer;

  localparam int  TIMEOUT = 16;
  localparam real MUL_K   = 17.0;
  localparam real SUB_C   = 3.14;
  localparam real DIV_K   = 21.0;
  localparam real ADD_E   = 2.718281828459045;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               in_valid = 1'b0;
  logic               alu_ack  = 1'b0;
  logic signed [31:0] a        = '0;
  real                b        = 0.0;
  logic               in_ready;
  logic               alu_req;
  logic               done;
  logic               err;
  logic [1:0]         alu_op;
  real                alu_x;
  real                alu_y;
  real                alu_z;
  real                xout [4];

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  int_real_sequencer #(
    .MUL_K(MUL_K), .SUB_C(SUB_C), .DIV_K(DIV_K), .ADD_E(ADD_E), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_req(alu_req), .alu_op(alu_op), .alu_x(alu_x),
    .alu_y(alu_y), .alu_ack(alu_ack), .alu_z(alu_z), .xout(xout),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Shared ALU environment.
  always_comb begin
    alu_z = 0.0;
    case (alu_op)
      2'd0:    alu_z = alu_x + alu_y;
      2'd1:    alu_z = alu_x - alu_y;
      2'd2:    alu_z = alu_x * alu_y;
      default: alu_z = (alu_y != 0.0) ? alu_x / alu_y : 0.0;
    endcase
  end

  // Model state and per-cycle expectations.
  logic       m_err = 1'b0;
  real        m_xout [4];
  logic       chk_en = 1'b0;
  logic       e_ready, e_req, e_done, e_err;
  logic [1:0] e_op;
  real        e_x, e_y;
  real        e_xout [4];
  int         w [6];
  logic       hold_valid = 1'b0;
  int         hold_a = 0;
  real        hold_b = 0.0;
  int         last_acc = -1;
  int         acc_gap = 0;
  int         last_lat = 0;

  function automatic bit feq(input real x, input real y);
    real d, m;
    d = x - y;
    if (d < 0.0) d = -d;
    m = (y < 0.0) ? -y : y;
    if (m < 1.0) m = 1.0;
    return d <= 1e-9 * m;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", nm, cycle, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cycle, act, exp);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real exp);
    compared++;
    if (!feq(act, exp)) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %.12g expected %.12g", nm, cycle, act, exp);
    end
  endtask

  // Single compare process, plus the operand-hold rule while req waits.
  logic       p_req = 1'b0, p_ack = 1'b0;
  logic [1:0] p_op = '0;
  real        p_x = 0.0, p_y = 0.0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk_bit("in_ready", in_ready, e_ready);
      chk_bit("alu_req", alu_req, e_req);
      chk_bit("done", done, e_done);
      chk_bit("err", err, e_err);
      if (e_req) begin
        chk_int("alu_op", int'(alu_op), int'(e_op));
        chk_real("alu_x", alu_x, e_x);
        chk_real("alu_y", alu_y, e_y);
      end
      for (int i = 0; i < 4; i++) chk_real($sformatf("xout[%0d]", i), xout[i], e_xout[i]);
    end
    if (p_req && !p_ack && alu_req) begin
      compared++;
      if (alu_op !== p_op || alu_x != p_x || alu_y != p_y) begin
        mismatched++;
        $display("FAIL alu_hold cycle %0d: op/x/y got %0d/%g/%g held %0d/%g/%g",
                 cycle, alu_op, alu_x, alu_y, p_op, p_x, p_y);
      end
    end
    p_req = alu_req; p_ack = alu_ack; p_op = alu_op; p_x = alu_x; p_y = alu_y;
    if (in_valid && in_ready && rst_n) begin
      if (last_acc >= 0) acc_gap = cycle - last_acc;
      last_acc = cycle;
    end
    if (done) last_lat = cycle - last_acc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input logic rdy, input logic req, input logic dn,
                            input logic [1:0] op, input real x, input real y);
    e_ready = rdy; e_req = req; e_done = dn; e_err = m_err;
    e_op = op; e_x = x; e_y = y;
    for (int i = 0; i < 4; i++) e_xout[i] = m_xout[i];
  endtask

  task automatic drive_busy();
    in_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
    a        = hold_valid ? hold_a : $urandom;
    b        = hold_valid ? hold_b : $itor($urandom_range(0, 2000)) / 10.0 - 100.0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      in_valid = 1'b0;
      alu_ack  = 1'($urandom_range(0, 1));
      expect_cyc(1'b1, 1'b0, 1'b0, 2'd0, 0.0, 0.0);
      step();
    end
  endtask

  task automatic reset_checks();
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk_bit("rst_alu_req", alu_req, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_err", err, 1'b0);
    chk_int("rst_alu_op", int'(alu_op), 0);
    chk_real("rst_alu_x", alu_x, 0.0);
    chk_real("rst_alu_y", alu_y, 0.0);
    for (int i = 0; i < 4; i++) chk_real($sformatf("rst_xout[%0d]", i), xout[i], 0.0);
  endtask

  // One transaction from an IDLE cycle; to_op = op that never gets ack,
  // rst_op = op during which reset is pulsed (-1 = none).
  task automatic run_txn(input int av, input real bv, input int to_op, input int rst_op);
    real        s0, s, t1, t2;
    real        xs [6];
    real        ys [6];
    logic [1:0] ops [6];
    s0  = $itor(av);
    s   = s0 + bv;
    t1  = s * MUL_K;
    t2  = s / DIV_K;
    xs  = '{s0, s, t1, s, t2, s};
    ys  = '{bv, MUL_K, SUB_C, DIV_K, ADD_E, 1.0};
    ops = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0};
    in_valid = 1'b1; a = av; b = bv;
    alu_ack  = 1'($urandom_range(0, 1));
    expect_cyc(1'b1, 1'b0, 1'b0, 2'd0, 0.0, 0.0);
    step();
    m_err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == rst_op) begin
        chk_en = 1'b0; alu_ack = 1'b0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_checks();
        for (int i = 0; i < 4; i++) m_xout[i] = 0.0;
        m_err = 1'b0;
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        return;
      end
      if (k == to_op) begin
        for (int c = 0; c < TIMEOUT; c++) begin
          drive_busy();
          alu_ack = 1'b0;
          expect_cyc(1'b0, 1'b1, 1'b0, ops[k], xs[k], ys[k]);
          step();
        end
        m_err = 1'b1;
        in_valid = 1'b0;
        return;
      end
      for (int c = 0; c <= w[k]; c++) begin
        drive_busy();
        alu_ack = (c == w[k]);
        expect_cyc(1'b0, 1'b1, 1'b0, ops[k], xs[k], ys[k]);
        step();
      end
    end
    drive_busy();
    alu_ack = 1'($urandom_range(0, 1));
    m_xout = '{s, s + 1.0, t2 + ADD_E, t1 - SUB_C};
    expect_cyc(1'b0, 1'b0, 1'b1, 2'd0, 0.0, 0.0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic set_w(input int v);
    for (int k = 0; k < 6; k++) w[k] = v;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) m_xout[i] = 0.0;
    repeat (2) @(posedge clk);
    #1 reset_checks();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Zero-wait reference transaction.
    set_w(0);
    run_txn(1, 0.5, -1, -1);
    chk_real("t1_xout3", xout[3], 22.36);
    chk_real("t1_xout2", xout[2], 2.789710399887617);
    chk_real("t1_xout1", xout[1], 2.5);
    chk_real("t1_xout0", xout[0], 1.5);
    chk_int("t1_latency", last_lat, 7);
    idle(2);

    // Three wait cycles per op.
    set_w(3);
    run_txn(-2, 0.25, -1, -1);
    chk_real("t2_xout3", xout[3], -32.89);
    chk_real("t2_xout1", xout[1], -0.75);
    chk_int("t2_latency", last_lat, 25);
    idle(1);

    // Timeout leaves the previous result intact.
    set_w(0);
    run_txn(1, 0.5, -1, -1);
    run_txn(5, 0.0, 0, -1);
    chk_bit("t3_err", err, 1'b1);
    chk_bit("t3_in_ready", in_ready, 1'b1);
    chk_real("t3_xout3", xout[3], 22.36);
    idle(1);

    // Back-to-back with in_valid held high.
    hold_valid = 1'b1; hold_a = 2; hold_b = 0.5;
    run_txn(1, 0.5, -1, -1);
    hold_valid = 1'b0;
    run_txn(2, 0.5, -1, -1);
    chk_int("t4_accept_gap", acc_gap, 8);
    idle(3);

    // Longest wait that still completes.
    set_w(TIMEOUT - 1);
    run_txn(7, -1.25, -1, -1);
    idle(1);

    // Reset in the middle of op3, then repeat the reference transaction.
    set_w(0);
    run_txn(1, 0.5, -1, 3);
    idle(1);
    run_txn(1, 0.5, -1, -1);
    chk_real("t5_xout3", xout[3], 22.36);
    chk_real("t5_xout2", xout[2], 2.789710399887617);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 6; k++)
        w[k] = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
      run_txn(int'($urandom_range(0, 2000)) - 1000,
              $itor($urandom_range(0, 20000)) / 100.0 - 100.0,
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : -1, -1);
      idle(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
